// File: rtl/i2c_pkg.sv
// Shared FSM state encoding and quarter-phase constants for the I2C byte master.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // SCL is high during the second half of every ordinary bit
  function automatic logic scl_for_quarter(input logic [1:0] q);
    return (q >= Q2);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit tick divider: one-clock tick every DIV clocks, held at zero while disabled.
module i2c_quarter_tick #(
  parameter int DIV = 5
) (
  input  logic clock,
  input  logic Reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] count;

  assign tick = enable && (count == CW'(DIV - 1));

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Single-master I2C byte engine: START, address, N data bytes (read or write), STOP.
// Optional build macro I2C_NACK_ABORT_EN: a slave NACK on address/write data jumps straight to STOP.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLOCK_FREQ = 60000000,
  parameter int BAUD_RATE  = 30000,
  parameter int CNT_W      = 4
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic             RnW,
  input  logic [6:0]       SlaveAddr,
  input  logic [CNT_W-1:0] ByteCount,
  input  logic [7:0]       TxData,
  output logic             TxNext,
  output logic [7:0]       RxData,
  output logic             RxValid,
  output logic             Busy,
  output logic             Done,
  output logic             Nack,
  output logic             SCL,
  inout  wire              SDA
);

  localparam int DIV = CLOCK_FREQ / (4 * BAUD_RATE);

  state_t           state, nstate;
  logic [1:0]       q, nq;
  logic [2:0]       bitcnt, nbit;
  logic [7:0]       shreg, nsh;
  logic [CNT_W-1:0] left, nleft;
  logic             rnw_r, nrnw;
  logic             nack_r, nnack;
  logic [7:0]       rx_r, nrx;
  logic             rxv_r, nrxv;
  logic             done_r, ndone;
  logic             scl_r, nscl;
  logic             sda_oe, noe;
  logic             tx_next;
  logic             tick;
  logic             abort;
  logic             sda_in;

  assign Busy    = (state != IDLE);
  assign TxNext  = tx_next;
  assign RxData  = rx_r;
  assign RxValid = rxv_r;
  assign Done    = done_r;
  assign Nack    = nack_r;
  assign SCL     = scl_r;
  assign SDA     = sda_oe ? 1'b0 : 1'bz;
  assign sda_in  = SDA;

`ifdef I2C_NACK_ABORT_EN
  assign abort = nack_r;
`else
  assign abort = 1'b0;
`endif

  i2c_quarter_tick #(.DIV(DIV)) u_tick (
    .clock  (clock),
    .Reset  (Reset),
    .enable (Busy),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      q      <= Q0;
      bitcnt <= '0;
      shreg  <= '0;
      left   <= '0;
      rnw_r  <= 1'b0;
      nack_r <= 1'b0;
      rx_r   <= '0;
      rxv_r  <= 1'b0;
      done_r <= 1'b0;
      scl_r  <= 1'b1;
      sda_oe <= 1'b0;
    end else begin
      state  <= nstate;
      q      <= nq;
      bitcnt <= nbit;
      shreg  <= nsh;
      left   <= nleft;
      rnw_r  <= nrnw;
      nack_r <= nnack;
      rx_r   <= nrx;
      rxv_r  <= nrxv;
      done_r <= ndone;
      scl_r  <= nscl;
      sda_oe <= noe;
    end
  end

  // Bus pins are registered from the upcoming state/quarter so SCL and SDA never glitch.
  always_comb begin
    nstate  = state;
    nq      = q;
    nbit    = bitcnt;
    nsh     = shreg;
    nleft   = left;
    nrnw    = rnw_r;
    nnack   = nack_r;
    nrx     = rx_r;
    nrxv    = 1'b0;
    ndone   = 1'b0;
    tx_next = 1'b0;
    nscl    = scl_r;
    noe     = sda_oe;

    if (state == IDLE) begin
      if (Go) begin
        nstate = START;
        nq     = Q0;
        nbit   = '0;
        nsh    = {SlaveAddr, RnW};
        nleft  = ByteCount;
        nrnw   = RnW;
        nnack  = 1'b0;
      end
    end else if (tick) begin
      nq = q + 2'd1;
      if (q == Q2) begin
        case (state)
          ADDR_ACK, WACK: if (sda_in) nnack = 1'b1;
          RDATA:          nsh = {shreg[6:0], sda_in};
          default:        ;
        endcase
      end
      if (q == Q3) begin
        nq = Q0;
        case (state)
          START: begin
            nstate = ADDR;
            nbit   = '0;
          end
          ADDR, WDATA: begin
            nsh  = {shreg[6:0], 1'b0};
            nbit = bitcnt + 3'd1;
            if (bitcnt == 3'd7) nstate = (state == ADDR) ? ADDR_ACK : WACK;
          end
          RDATA: begin
            nbit = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              nstate = RACK;
              nrx    = shreg;
              nrxv   = 1'b1;
            end
          end
          ADDR_ACK, WACK: begin
            if (left == '0 || abort) begin
              nstate = STOP;
            end else if (rnw_r) begin
              nstate = RDATA;
              nleft  = left - 1'b1;
            end else begin
              nstate  = WDATA;
              nleft   = left - 1'b1;
              nsh     = TxData;
              tx_next = 1'b1;
            end
          end
          RACK: begin
            if (left == '0) begin
              nstate = STOP;
            end else begin
              nstate = RDATA;
              nleft  = left - 1'b1;
            end
          end
          STOP: begin
            nstate = IDLE;
            ndone  = 1'b1;
          end
          default: nstate = IDLE;
        endcase
      end
    end

    // left is already decremented on RACK entry, so zero marks the final byte (NACK)
    case (nstate)
      IDLE: begin
        nscl = 1'b1;
        noe  = 1'b0;
      end
      START: begin
        nscl = (nq < Q2);
        noe  = 1'b1;
      end
      ADDR, WDATA: begin
        nscl = scl_for_quarter(nq);
        noe  = ~nsh[7];
      end
      RACK: begin
        nscl = scl_for_quarter(nq);
        noe  = (nleft != '0);
      end
      STOP: begin
        nscl = scl_for_quarter(nq);
        noe  = (nq != Q3);
      end
      default: begin
        nscl = scl_for_quarter(nq);
        noe  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with a bit-level I2C slave model on a pulled-up SDA.
module tb_i2c_byte_master;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       go = 1'b0;
  logic       rnw = 1'b0;
  logic [6:0] slave_addr = 7'h48;
  logic [3:0] byte_count = 4'd0;
  logic [7:0] tx_data;
  logic       tx_next;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl;
  wire        sda;

  int tests  = 0;
  int failed = 0;

  logic [7:0] tx_bytes [0:3];
  logic [7:0] rd_bytes [0:1];
  logic       ack_en = 1'b1;

  int         tx_idx = 0;
  int         rx_n = 0;
  logic [7:0] rx_byte [0:3];
  int         done_n = 0;
  logic       busy_q = 1'b0;

  int         start_n = 0;
  int         stop_n = 0;
  int         log_n = 0;
  logic [7:0] log_byte [0:7];
  logic       log_ack [0:7];
  logic       slave_oe = 1'b0;
  int         bitn = 0;
  int         bytei = 0;
  logic [7:0] cap = 8'h00;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       rd_mode;

  always #5 clock = ~clock;

  assign sda     = slave_oe ? 1'b0 : 1'bz;
  pullup (sda);
  assign tx_data = tx_bytes[tx_idx];

  i2c_byte_master #(
    .CLOCK_FREQ (40),
    .BAUD_RATE  (2),
    .CNT_W      (4)
  ) dut (
    .clock     (clock),
    .Reset     (rst_n),
    .Go        (go),
    .RnW       (rnw),
    .SlaveAddr (slave_addr),
    .ByteCount (byte_count),
    .TxData    (tx_data),
    .TxNext    (tx_next),
    .RxData    (rx_data),
    .RxValid   (rx_valid),
    .Busy      (busy),
    .Done      (done),
    .Nack      (nack),
    .SCL       (scl),
    .SDA       (sda)
  );

  // Per-transfer counters restart on each rising Busy; TxData advances just after the loading edge.
  always @(negedge clock) begin
    if (busy && !busy_q) begin
      tx_idx = 0;
      rx_n   = 0;
    end
    busy_q = busy;
    if (done) done_n++;
    if (rx_valid && rx_n < 4) begin
      rx_byte[rx_n] = rx_data;
      rx_n++;
    end
    if (tx_next) begin
      @(posedge clock);
      #1;
      if (tx_idx < 3) tx_idx++;
    end
  end

  assign rd_mode = (bytei >= 1) && log_byte[0][0];

  // Slave: logs every byte with its ninth-clock SDA level, ACKs master bytes, drives read data.
  always @(negedge clock) begin
    if (prev_scl && scl && prev_sda && !sda) begin
      start_n++;
      bitn     = 0;
      bytei    = 0;
      log_n    = 0;
      slave_oe = 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      stop_n++;
    end else if (!prev_scl && scl) begin
      if (bitn < 8) begin
        cap = {cap[6:0], sda};
        bitn++;
      end else begin
        if (bytei < 8) begin
          log_byte[bytei] = cap;
          log_ack[bytei]  = sda;
        end
        log_n++;
        bytei++;
        bitn = 0;
      end
    end else if (prev_scl && !scl) begin
      slave_oe = 1'b0;
      if (bitn == 8) begin
        if (!rd_mode) slave_oe = ack_en;
      end else if (rd_mode && bytei <= 2) begin
        slave_oe = ~rd_bytes[bytei-1][3'(7 - bitn)];
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [6:0] a, input logic [3:0] n);
    @(negedge clock);
    rnw        = r;
    slave_addr = a;
    byte_count = n;
    go         = 1'b1;
    @(negedge clock);
    go = 1'b0;
    check_output("busy_after_go", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int base = done_n;
    int n = 0;
    while (done_n == base && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check_output({tag, "_done"}, 32'(done_n != base), 32'd1);
    @(negedge clock);
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int sbase;
    int dbase;
    int n;
    tx_bytes[0] = 8'hA5;
    tx_bytes[1] = 8'h3C;
    tx_bytes[2] = 8'h00;
    tx_bytes[3] = 8'h00;
    rd_bytes[0] = 8'h19;
    rd_bytes[1] = 8'h80;

    #2 rst_n = 1'b0;
    #1;
    check_output("rst_scl", 32'(scl), 32'd1);
    check_output("rst_sda", 32'(sda), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_nack", 32'(nack), 32'd0);
    check_output("rst_txnext", 32'(tx_next), 32'd0);
    check_output("rst_rxvalid", 32'(rx_valid), 32'd0);
    check_output("rst_rxdata", 32'(rx_data), 32'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;

    // Two-byte write
    sbase = stop_n;
    apply_stimulus(1'b0, 7'h48, 4'd2);
    wait_done("wr");
    check_output("wr_bytes", 32'(log_n), 32'd3);
    check_output("wr_addr", 32'(log_byte[0]), 32'h90);
    check_output("wr_d0", 32'(log_byte[1]), 32'hA5);
    check_output("wr_d1", 32'(log_byte[2]), 32'h3C);
    check_output("wr_acks", 32'({log_ack[0], log_ack[1], log_ack[2]}), 32'd0);
    check_output("wr_txnext", 32'(tx_idx), 32'd2);
    check_output("wr_nack", 32'(nack), 32'd0);
    check_output("wr_stop", 32'(stop_n - sbase), 32'd1);
    check_output("wr_done_pulse", 32'(done), 32'd0);

    // Two-byte read
    sbase = stop_n;
    apply_stimulus(1'b1, 7'h48, 4'd2);
    wait_done("rd");
    check_output("rd_addr", 32'(log_byte[0]), 32'h91);
    check_output("rd_addr_ack", 32'(log_ack[0]), 32'd0);
    check_output("rd_rxcount", 32'(rx_n), 32'd2);
    check_output("rd_rx0", 32'(rx_byte[0]), 32'h19);
    check_output("rd_rx1", 32'(rx_byte[1]), 32'h80);
    check_output("rd_master_ack", 32'(log_ack[1]), 32'd0);
    check_output("rd_master_nack", 32'(log_ack[2]), 32'd1);
    check_output("rd_stop", 32'(stop_n - sbase), 32'd1);
    check_output("rd_rxdata", 32'(rx_data), 32'h80);

    // Address NACK with three bytes requested
    ack_en = 1'b0;
    sbase  = stop_n;
    apply_stimulus(1'b0, 7'h48, 4'd3);
    wait_done("an");
    check_output("an_nack", 32'(nack), 32'd1);
    check_output("an_addr_ack", 32'(log_ack[0]), 32'd1);
    check_output("an_stop", 32'(stop_n - sbase), 32'd1);
`ifdef I2C_NACK_ABORT_EN
    check_output("an_txnext", 32'(tx_idx), 32'd0);
    check_output("an_bytes", 32'(log_n), 32'd1);
`else
    check_output("an_txnext", 32'(tx_idx), 32'd3);
    check_output("an_bytes", 32'(log_n), 32'd4);
`endif
    ack_en = 1'b1;

    // Zero-length write with a stray Go while busy
    sbase = start_n;
    dbase = done_n;
    apply_stimulus(1'b0, 7'h48, 4'd0);
    check_output("zl_nack_cleared", 32'(nack), 32'd0);
    repeat (100) @(negedge clock);
    slave_addr = 7'h7F;
    go         = 1'b1;
    @(negedge clock);
    go = 1'b0;
    wait_done("zl");
    repeat (60) @(negedge clock);
    check_output("zl_still_idle", 32'(busy), 32'd0);
    check_output("zl_one_done", 32'(done_n - dbase), 32'd1);
    check_output("zl_one_start", 32'(start_n - sbase), 32'd1);
    check_output("zl_bytes", 32'(log_n), 32'd1);
    check_output("zl_addr", 32'(log_byte[0]), 32'h90);
    check_output("zl_txnext", 32'(tx_idx), 32'd0);
    check_output("zl_rxvalid", 32'(rx_n), 32'd0);

    // Reset partway through the second data byte
    tx_bytes[0] = 8'h11;
    tx_bytes[1] = 8'h22;
    tx_bytes[2] = 8'h33;
    apply_stimulus(1'b0, 7'h48, 4'd3);
    n = 0;
    while (tx_idx < 2 && n < 4000) begin
      @(negedge clock);
      n++;
    end
    check_output("mr_reached_byte2", 32'(tx_idx >= 2), 32'd1);
    repeat (50) @(negedge clock);
    rst_n = 1'b0;
    #1;
    check_output("mr_scl", 32'(scl), 32'd1);
    check_output("mr_sda", 32'(sda), 32'd1);
    check_output("mr_busy", 32'(busy), 32'd0);
    check_output("mr_rxdata", 32'(rx_data), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    tx_bytes[0] = 8'h5A;
    apply_stimulus(1'b0, 7'h48, 4'd1);
    wait_done("pr");
    check_output("pr_bytes", 32'(log_n), 32'd2);
    check_output("pr_addr", 32'(log_byte[0]), 32'h90);
    check_output("pr_data", 32'(log_byte[1]), 32'h5A);
    check_output("pr_txnext", 32'(tx_idx), 32'd1);
    check_output("pr_nack", 32'(nack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
